counter_down_load_timer: RTL
============================

Name: counter_down_load_timer

Overview:
- Loadable N-bit down-counter/timer with borrow output: the decrementing counterpart to the team's loadable up-counter with carry-out.
- Counts a loaded value down to terminal count, then pulses TC and either stops (one-shot) or auto-reloads (periodic).
- Used as a programmable interval/timeout generator beside the up-counters in datapath control.

Parameters:
N, 8, counter/data width in bits (N >= 2)

Ports:
CLK  input  1  clock, rising edge
ASYNCRESET  input  1  asynchronous reset, active-high
DATA  input  N  load value (count period)
LOAD  input  1  synchronous load strobe; highest priority after reset
EN  input  1  count enable; decrement only when high
PERIODIC  input  1  sampled at LOAD: 1 = auto-reload, 0 = one-shot
O  output  N  current count (registered)
COUT  output  1  borrow-out of O-1; combinational, = (O == 0)
TC  output  1  terminal-count pulse (registered, one cycle)
BUSY  output  1  high while state == RUN (registered)

Behaviour:
- Interface: one clock CLK; reset ASYNCRESET is asynchronous and active-high.
- Internal state: count register (N bits), reload register (N bits), mode bit, FSM {IDLE, RUN}.
- Reset (async, any time, including mid-count): count=0, reload=0, mode=0, state=IDLE, TC=0, BUSY=0. Hence O=0 and COUT=1.
- Reset release: no activity until LOAD.
- Priority per rising edge: ASYNCRESET > LOAD > count step > hold.
- LOAD=1 (any state, EN ignored):
  - count<=DATA, reload<=DATA, mode<=PERIODIC, TC<=0.
  - DATA!=0: state<=RUN. DATA==0: state<=IDLE.
  - A LOAD in the same cycle as a would-be terminal step wins; TC is not asserted.
- IDLE, LOAD=0: count holds; TC<=0; EN ignored.
- RUN, LOAD=0, EN=0: count holds, TC<=0, state holds.
- RUN, LOAD=0, EN=1, count>1: count<=count-1, TC<=0.
- RUN, LOAD=0, EN=1, count==1 (terminal step): TC<=1 for exactly one cycle.
  - mode=1: count<=reload, stay RUN.
  - mode=0: count<=0, state<=IDLE.
- Latency and period:
  - After LOAD of D (D>0) with EN held high, TC is high in the cycle after the D-th enabled edge following the LOAD edge.
  - Periodic mode: TC every D enabled cycles, i.e. a period of D cycles with EN=1. D=1 gives TC continuously high.
- Arithmetic: modulo-2^N. count never decrements from 0 (0 is reachable only in IDLE), so no wrap to all-ones.
- COUT: purely combinational from O; no state dependence.
- BUSY: equals (state==RUN), registered with the state.
- Changing DATA or PERIODIC without LOAD has no effect.

Test Plan:
- Reset: assert ASYNCRESET mid-RUN, between clock edges -> immediately O=0, COUT=1, TC=0, BUSY=0. No change on further edges until LOAD.
- One-shot: LOAD DATA=3, PERIODIC=0, then EN=1 -> O=3,2,1,0 on successive edges. TC=1 only in the cycle O becomes 0. BUSY drops the same cycle. COUT=1 from then on. O holds at 0.
- Periodic with EN gaps: LOAD DATA=4, PERIODIC=1, EN toggling 1,0,1,1,1 -> O=4,3,3,2,1,4. TC pulses once when O returns to 4. BUSY stays 1.
- LOAD collision: O=1, EN=1, LOAD=1, DATA=0x80 -> next O=0x80, TC=0, BUSY=1.
- Zero load and wide value (N=8): LOAD DATA=0 -> O=0, BUSY=0, COUT=1, no TC. LOAD DATA=0xFF, periodic, EN=1 -> first TC after 255 edges, O=0xFF. O is never 0x00 and COUT stays 0 throughout.
- Periodic with DATA=1: TC=1 on every enabled cycle and O stays 1. Drop EN -> TC=0 next cycle.

Source files
------------

// File: rtl/counter_down_load_timer_if.sv
// Control and status bundle for the loadable down-counter/timer.
// master drives load/enable/mode, slave (the timer) returns count and flags.
interface counter_down_load_timer_if #(
    parameter int N = 8
);
    logic [N-1:0] DATA;
    logic         LOAD;
    logic         EN;
    logic         PERIODIC;
    logic [N-1:0] O;
    logic         COUT;
    logic         TC;
    logic         BUSY;

    modport master (
        output DATA, LOAD, EN, PERIODIC,
        input  O, COUT, TC, BUSY
    );

    modport slave (
        input  DATA, LOAD, EN, PERIODIC,
        output O, COUT, TC, BUSY
    );
endinterface

// File: rtl/counter_down_load_timer.sv
// Loadable N-bit down-counter/timer. Counts a loaded period down to zero,
// pulses TC on the terminal step, then either stops (one-shot) or reloads
// the period (periodic). COUT is the borrow of O-1, i.e. O == 0.
module counter_down_load_timer #(
    parameter int N = 8
) (
    input  logic                           CLK,
    input  logic                           ASYNCRESET,
    counter_down_load_timer_if.slave       bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state;
    logic [N-1:0] count;
    logic [N-1:0] reload;
    logic         mode;
    logic         tc;

    // Timer FSM: load has priority over counting; count only moves in RUN,
    // so it never decrements from zero and never wraps to all-ones.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            mode   <= 1'b0;
            tc     <= 1'b0;
        end else if (bus.LOAD) begin
            count  <= bus.DATA;
            reload <= bus.DATA;
            mode   <= bus.PERIODIC;
            tc     <= 1'b0;
            state  <= (bus.DATA != '0) ? RUN : IDLE;
        end else begin
            tc <= 1'b0;
            case (state)
                IDLE: ;
                RUN: begin
                    if (bus.EN) begin
                        if (count == ONE) begin
                            tc <= 1'b1;
                            if (mode) begin
                                count <= reload;
                            end else begin
                                count <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            count <= count - ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs: count, TC and BUSY come straight from flops; COUT decodes O.
    assign bus.O    = count;
    assign bus.TC   = tc;
    assign bus.BUSY = (state == RUN);
    assign bus.COUT = (count == '0);

endmodule
